// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames 55 AA CMD LEN D.. CS byte streams from the UART rx path.
// Optional inter-byte timeout is built in with `define UART_CMD_TIMEOUT_EN.
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned TIMEOUT_CYC = 312500
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_done_i,
  output logic                 frame_valid_o,
  output logic [7:0]           cmd_o,
  output logic [3:0]           len_o,
  output logic [MAX_LEN*8-1:0] payload_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o,
  output logic                 busy_o
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  // LEN reaches len_o through 4 bits and the counter is 20 bits wide
  if (MAX_LEN < 1 || MAX_LEN > 15 ||
      TIMEOUT_CYC < 2 || TIMEOUT_CYC > 1048576) begin : g_bad_params
    $error("uart_cmd_parser: unsupported parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR2,
    S_CMD,
    S_LEN,
    S_DATA,
    S_CSUM
  } state_t;

  state_t state_q, state_d;

  logic [7:0]               cmd_q;
  logic [3:0]               len_q;
  logic [3:0]               idx_q;
  logic [7:0]               sum_q;
  logic [MAX_LEN-1:0][7:0]  shadow_q;

  logic       ok_pulse;
  logic       err_pulse;
  logic [1:0] err_code_d;
  logic       len_bad;
  logic       last_data;
  logic       tmo_hit;

  assign len_bad   = rx_data_i > 8'(MAX_LEN);
  assign last_data = idx_q == (len_q - 4'd1);
  assign busy_o    = state_q != S_IDLE;

`ifdef UART_CMD_TIMEOUT_EN
  logic [19:0] tmo_cnt_q;

  assign tmo_hit = busy_o && !rx_done_i &&
                   (tmo_cnt_q == 20'(TIMEOUT_CYC - 1));

  // Inter-byte idle counter; restarts on every byte and while idle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_cnt_q <= '0;
    end else if (rx_done_i || !busy_o) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 20'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and frame verdict; a byte always wins over timeout
  always_comb begin
    state_d    = state_q;
    ok_pulse   = 1'b0;
    err_pulse  = 1'b0;
    err_code_d = 2'd0;
    if (rx_done_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data_i == 8'h55) state_d = S_HDR2;
        end
        S_HDR2: begin
          if (rx_data_i == 8'hAA)      state_d = S_CMD;
          else if (rx_data_i == 8'h55) state_d = S_HDR2;
          else                         state_d = S_IDLE;
        end
        S_CMD: begin
          state_d = S_LEN;
        end
        S_LEN: begin
          if (len_bad) begin
            err_pulse  = 1'b1;
            err_code_d = 2'd1;
            state_d    = S_IDLE;
          end else if (rx_data_i == 8'h00) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (last_data) state_d = S_CSUM;
        end
        S_CSUM: begin
          if (rx_data_i == sum_q) begin
            ok_pulse = 1'b1;
          end else begin
            err_pulse  = 1'b1;
            err_code_d = 2'd2;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_hit) begin
      err_pulse  = 1'b1;
      err_code_d = 2'd3;
      state_d    = S_IDLE;
    end
  end

  // Frame capture into shadow, published only on a good checksum
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmd_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      sum_q         <= '0;
      shadow_q      <= '0;
      frame_valid_o <= 1'b0;
      err_o         <= 1'b0;
      err_code_o    <= '0;
      cmd_o         <= '0;
      len_o         <= '0;
      payload_o     <= '0;
    end else begin
      frame_valid_o <= ok_pulse;
      err_o         <= err_pulse;
      if (err_pulse) err_code_o <= err_code_d;
      if (ok_pulse) begin
        cmd_o     <= cmd_q;
        len_o     <= len_q;
        payload_o <= shadow_q;
      end
      if (rx_done_i) begin
        unique case (state_q)
          S_CMD: begin
            cmd_q <= rx_data_i;
            sum_q <= rx_data_i;
          end
          S_LEN: begin
            if (!len_bad) begin
              len_q    <= rx_data_i[3:0];
              sum_q    <= sum_q + rx_data_i;
              idx_q    <= '0;
              shadow_q <= '0;
            end
          end
          S_DATA: begin
            shadow_q[idx_q[IDX_W-1:0]] <= rx_data_i;
            sum_q <= sum_q + rx_data_i;
            idx_q <= idx_q + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
